// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with fill level,
// almost-full/almost-empty thresholds, sticky overflow/underflow and a
// synchronous flush. Handshake matches the async FIFO (winc/wfull, rinc/rempty).
module sync_fifo_param #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  output logic             overflow,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic             underflow,
  output logic [ASIZE:0]   count
);

  localparam int DEPTH = 1 << ASIZE;

  // Thresholds sized to the count register so every compare is width-matched.
  localparam logic [ASIZE:0] DEPTH_V   = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_V      = (ASIZE+1)'(AF_THRESH);
  localparam logic [ASIZE:0] AE_V      = (ASIZE+1)'(AE_THRESH);
  localparam logic [ASIZE:0] ONE_V     = (ASIZE+1)'(1);
  localparam logic [ASIZE:0] ZERO_V    = (ASIZE+1)'(0);
  localparam logic [DSIZE-1:0] DZERO_V = (DSIZE)'(0);

  logic [DSIZE-1:0] mem_q [DEPTH];

  // Pointers carry one extra bit so they wrap at 2*DEPTH; memory uses the low bits.
  logic [ASIZE:0]   wptr_q, wptr_d;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic [ASIZE:0]   count_q, count_d;
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             full_s;
  logic             empty_s;
  logic             write_accept;
  logic             read_accept;
  logic             mem_we;

  // Status flags decode the registered fill level.
  always_comb begin
    full_s        = (count_q == DEPTH_V);
    empty_s       = (count_q == ZERO_V);
    walmost_full  = (count_q >= AF_V);
    ralmost_empty = (count_q <= AE_V);
  end

  // Next-state for pointers, level, read data and sticky errors; flush wins over traffic.
  always_comb begin
    write_accept = winc & ~full_s;
    read_accept  = rinc & ~empty_s;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    rdata_d      = rdata_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    mem_we       = 1'b0;
    if (clr) begin
      wptr_d      = ZERO_V;
      rptr_d      = ZERO_V;
      count_d     = ZERO_V;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      overflow_d  = overflow_q | (winc & full_s);
      underflow_d = underflow_q | (rinc & empty_s);
      if (write_accept) begin
        mem_we = 1'b1;
        wptr_d = wptr_q + ONE_V;
      end else begin
        wptr_d = wptr_q;
      end
      if (read_accept) begin
        rdata_d = mem_q[rptr_q[ASIZE-1:0]];
        rptr_d  = rptr_q + ONE_V;
      end else begin
        rdata_d = rdata_q;
      end
      case ({write_accept, read_accept})
        2'b10:   count_d = count_q + ONE_V;
        2'b01:   count_d = count_q - ONE_V;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= ZERO_V;
      rptr_q      <= ZERO_V;
      count_q     <= ZERO_V;
      rdata_q     <= DZERO_V;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wptr_q[ASIZE-1:0]] <= wdata;
    end
  end

  assign wfull     = full_s;
  assign rempty    = empty_s;
  assign count     = count_q;
  assign rdata     = rdata_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DSIZE=8, ASIZE=4).
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       winc;
  logic [7:0] wdata;
  logic       wfull;
  logic       walmost_full;
  logic       overflow;
  logic       rinc;
  logic [7:0] rdata;
  logic       rempty;
  logic       ralmost_empty;
  logic       underflow;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  sync_fifo_param #(
    .DSIZE(8), .ASIZE(4), .AF_THRESH(12), .AE_THRESH(2)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .winc(winc), .wdata(wdata), .wfull(wfull),
    .walmost_full(walmost_full), .overflow(overflow),
    .rinc(rinc), .rdata(rdata), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .underflow(underflow),
    .count(count)
  );

  always #5 clk = ~clk;

  // advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
    tick(); tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL reset_rempty got %b exp 1", rempty); end
    checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull got %b exp 0", wfull); end
    checks++; if (ralmost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got %b exp 1", ralmost_empty); end
    checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", walmost_full); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", rdata); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {overflow, underflow}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1; wdata = 8'(i);
      tick();
      checks++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
      checks++; if (walmost_full !== (i + 1 >= 12)) begin errors++; $display("FAIL fill_af[%0d] got %b exp %b", i, walmost_full, (i + 1 >= 12)); end
      checks++; if (wfull !== (i == 15)) begin errors++; $display("FAIL fill_wfull[%0d] got %b exp %b", i, wfull, (i == 15)); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got %b exp 0", overflow); end
    wdata = 8'hAA;
    tick();
    winc = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b exp 1", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count_17 got %0d exp 16", count); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      rinc = 1'b1;
      tick();
      checks++; if (rdata !== 8'(i)) begin errors++; $display("FAIL drain_rdata[%0d] got %h exp %h", i, rdata, 8'(i)); end
      checks++; if (count !== 5'(15 - i)) begin errors++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, count, 15 - i); end
      checks++; if (ralmost_empty !== (15 - i <= 2)) begin errors++; $display("FAIL drain_ae[%0d] got %b exp %b", i, ralmost_empty, (15 - i <= 2)); end
      checks++; if (rempty !== (i == 15)) begin errors++; $display("FAIL drain_rempty[%0d] got %b exp %b", i, rempty, (i == 15)); end
    end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL drain_no_unf got %b exp 0", underflow); end
    tick();
    rinc = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL drain_underflow got %b exp 1", underflow); end
    checks++; if (rdata !== 8'h0F) begin errors++; $display("FAIL drain_rdata_hold got %h exp 0f", rdata); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL drain_count_end got %0d exp 0", count); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_d;
    // clear sticky errors from the previous scenarios
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL sim_clr_err got %b exp 00", {overflow, underflow}); end
    // empty with both requests: write only
    winc = 1'b1; rinc = 1'b1; wdata = 8'h55;
    tick();
    rinc = 1'b0;
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL sim_empty_count got %0d exp 1", count); end
    checks++; if (rdata !== 8'h0F) begin errors++; $display("FAIL sim_empty_rdata got %h exp 0f", rdata); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL sim_empty_unf got %b exp 1", underflow); end
    for (int i = 1; i < 5; i++) begin
      wdata = 8'h55 + 8'(i);
      tick();
    end
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL sim_pre_count got %0d exp 5", count); end
    // steady stream across pointer wrap
    rinc = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wdata = 8'h60 + 8'(i);
      tick();
      exp_d = (i < 5) ? (8'h55 + 8'(i)) : (8'h60 + 8'(i - 5));
      checks++; if (rdata !== exp_d) begin errors++; $display("FAIL sim_rdata[%0d] got %h exp %h", i, rdata, exp_d); end
      checks++; if (count !== 5'd5) begin errors++; $display("FAIL sim_count[%0d] got %0d exp 5", i, count); end
    end
    rinc = 1'b0;
    // fill up: queue is 6F..73 then 80..8A
    for (int i = 0; i < 11; i++) begin
      wdata = 8'h80 + 8'(i);
      tick();
    end
    checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL sim_full got %b exp 1", wfull); end
    // full with both requests: read only, overflow
    rinc = 1'b1; wdata = 8'hEE;
    tick();
    winc = 1'b0; rinc = 1'b0;
    checks++; if (count !== 5'd15) begin errors++; $display("FAIL sim_full_count got %0d exp 15", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sim_full_ovf got %b exp 1", overflow); end
    checks++; if (rdata !== 8'h6F) begin errors++; $display("FAIL sim_full_rdata got %h exp 6f", rdata); end
  endtask

  task automatic test_flush();
    // read 70,71,72,73,80,81 down to count 9
    rinc = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    rinc = 1'b0;
    checks++; if (count !== 5'd9) begin errors++; $display("FAIL flush_pre_count got %0d exp 9", count); end
    checks++; if (rdata !== 8'h81) begin errors++; $display("FAIL flush_pre_rdata got %h exp 81", rdata); end
    clr = 1'b1; winc = 1'b1; rinc = 1'b1; wdata = 8'h99;
    tick();
    clr = 1'b0; winc = 1'b0; rinc = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL flush_rempty got %b exp 1", rempty); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL flush_err got %b exp 00", {overflow, underflow}); end
    checks++; if (rdata !== 8'h81) begin errors++; $display("FAIL flush_rdata got %h exp 81", rdata); end
    // after flush the first entry out is the first written after it
    winc = 1'b1; wdata = 8'h42;
    tick();
    winc = 1'b0; rinc = 1'b1;
    tick();
    rinc = 1'b0;
    checks++; if (rdata !== 8'h42) begin errors++; $display("FAIL flush_post_rdata got %h exp 42", rdata); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL flush_post_count got %0d exp 0", count); end
  endtask

  task automatic test_async_reset();
    winc = 1'b1;
    wdata = 8'h11; tick();
    wdata = 8'h22; tick();
    wdata = 8'h33; rinc = 1'b1; tick();
    checks++; if (rdata !== 8'h11) begin errors++; $display("FAIL arst_pre_rdata got %h exp 11", rdata); end
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL arst_pre_count got %0d exp 2", count); end
    // burst still running; hit reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL arst_count got %0d exp 0", count); end
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL arst_rempty got %b exp 1", rempty); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL arst_rdata got %h exp 00", rdata); end
    checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL arst_wfull got %b exp 0", wfull); end
    winc = 1'b0; rinc = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    winc = 1'b1; wdata = 8'h3C;
    tick();
    winc = 1'b0; rinc = 1'b1;
    tick();
    rinc = 1'b0;
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL arst_post_rdata got %h exp 3c", rdata); end
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL arst_post_rempty got %b exp 1", rempty); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO; the next generation of the team's async FIFO.
- Same winc/wdata/wfull and rinc/rdata/rempty handshake, so existing write/read drivers and monitors reuse unchanged.
- Adds configurable width/depth, fill-level output, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.
- Sits between producer and consumer blocks sharing one clock domain.

Parameters:
- DSIZE, 8, data width in bits.
- ASIZE, 4, address width; DEPTH = 2**ASIZE entries.
- AF_THRESH, 12, walmost_full asserts when count >= AF_THRESH (legal range 1..DEPTH).
- AE_THRESH, 2, ralmost_empty asserts when count <= AE_THRESH (legal range 0..DEPTH-1).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous flush.
- winc  input  1  write request.
- wdata  input  DSIZE  write data.
- wfull  output  1  FIFO full.
- walmost_full  output  1  count >= AF_THRESH.
- overflow  output  1  sticky: write attempted while full.
- rinc  input  1  read request.
- rdata  output  DSIZE  read data, registered.
- rempty  output  1  FIFO empty.
- ralmost_empty  output  1  count <= AE_THRESH.
- underflow  output  1  sticky: read attempted while empty.
- count  output  ASIZE+1  current fill level, 0..DEPTH.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: wptr=rptr=0, count=0, rdata=0, overflow=0, underflow=0. Therefore rempty=1, wfull=0, ralmost_empty=1, walmost_full=(AF_THRESH==0 ? 1 : 0), which is 0 for legal values.
- rst asserted mid-operation clears all state immediately, with no clock needed. Contents are discarded; memory array itself is not cleared.
- Pointers are ASIZE+1 bits. Memory is indexed by the low ASIZE bits. Pointers wrap from 2*DEPTH-1 to 0 naturally.
- Write accept: wa = winc & ~wfull. Read accept: ra = rinc & ~rempty. Both evaluated on pre-edge state.
- On wa: mem[wptr] <= wdata; wptr += 1.
- On ra: rdata <= mem[rptr]; rptr += 1. rdata is valid the cycle after the accepting edge and holds until the next accepted read.
- count next value:
  - count + 1 if wa & ~ra.
  - count - 1 if ra & ~wa.
  - unchanged if both or neither.
- Flags are combinational from the registered count, so they update in the cycle after the accepting edge:
  - wfull = (count == DEPTH).
  - rempty = (count == 0).
- Simultaneous winc & rinc:
  - Empty: write only; rdata unchanged.
  - Full: read only; write rejected, overflow set.
  - Otherwise: both accepted, count unchanged.
- Read-during-write to the same entry is impossible (ra requires count >= 1), so no bypass path.
- Sticky errors: overflow <= 1 when winc & wfull; underflow <= 1 when rinc & rempty. Both are cleared only by rst or clr.
- clr (synchronous, priority over winc/rinc that cycle):
  - wptr=rptr=count=0; overflow=underflow=0.
  - rdata holds its value; no write or read is performed.
- Must be clean at DEPTH=2 (ASIZE=1) and when AF_THRESH==DEPTH (walmost_full equals wfull).

Test Plan:
- Reset then fill: DSIZE=8, ASIZE=4; write 0x00..0x0F on 16 consecutive cycles. Required: count=1..16; walmost_full first high after the 12th write; wfull high after the 16th. A 17th write (0xAA) sets overflow=1 and count stays 16.
- Drain: from full, assert rinc 16 cycles. Required: rdata sequence 0x00..0x0F, each one cycle after its read edge. ralmost_empty asserts when count=2. rempty=1 after the last read. An extra rinc sets underflow=1 and rdata holds 0x0F.
- Simultaneous ops: count=5 with winc&rinc for 20 cycles. Required: count stays 5, data order preserved across pointer wrap. When full with winc&rinc: count→15, overflow=1. When empty with winc&rinc: count→1, rdata unchanged.
- Flush: count=9, overflow=1; pulse clr together with winc&rinc. Required next cycle: count=0, rempty=1, overflow=0, rdata unchanged, no data written.
- Async reset mid-stream: assert rst between clock edges during a burst. Required: outputs reach reset values before the next edge. After release, write 0x3C and read it back: rdata=0x3C.
